// File: rtl/decodificador_gestos_pkg.sv
// Shared definitions for the gesture decoder: per-button FSM state encoding,
// default timing constants (25 MHz clock) and the counter width helper.
package decodificador_gestos_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPress1   = 3'd1,
    StWait2    = 3'd2,
    StPress2   = 3'd3,
    StHeld     = 3'd4,
    StSuppress = 3'd5
  } gesto_state_e;

  localparam int unsigned DefDebounceCyc = 250000;    // 10 ms
  localparam int unsigned DefHoldCyc     = 25000000;  // 1 s
  localparam int unsigned DefDclickCyc   = 7500000;   // 300 ms

  // Width able to hold the largest of the three cycle counts.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/canal_gesto.sv
// One button channel: 2-FF synchronizer, debouncer and gesture FSM.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   raw         - raw button, active-high, asynchronous to clk
//   suppress    - forces/holds the FSM in SUPPRESS (combo in progress)
//   level       - debounced level
//   click, dclick, hold - one-cycle registered gesture pulses
module canal_gesto
  import decodificador_gestos_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
  parameter int unsigned HOLD_CYC     = DefHoldCyc,
  parameter int unsigned DCLICK_CYC   = DefDclickCyc
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic suppress,
  output logic level,
  output logic click,
  output logic dclick,
  output logic hold
);

  localparam int unsigned CntW = cnt_width(DEBOUNCE_CYC, HOLD_CYC, DCLICK_CYC);
  localparam logic [CntW-1:0] DbLast = CntW'(DEBOUNCE_CYC - 1);
  // The FSM reacts one cycle after the level edge, so its terminal counts are one
  // short; hold/click then land HOLD_CYC/DCLICK_CYC cycles after the level edge.
  localparam logic [CntW-1:0] HoldLast  = CntW'((HOLD_CYC > 1) ? HOLD_CYC - 2 : 0);
  localparam logic [CntW-1:0] ClickLast = CntW'((DCLICK_CYC > 1) ? DCLICK_CYC - 2 : 0);

  // ---------------- synchronizer + debouncer ----------------
  logic            sync1_q, sync2_q;
  logic            level_q, flip_q;
  logic [CntW-1:0] db_cnt_q;

  // The flip is registered once the count completes, so the level edge lands
  // 2 + DEBOUNCE_CYC cycles after the raw value is first sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      flip_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_q ^ flip_q;
      flip_q  <= 1'b0;
      if (flip_q || (sync2_q == level_q)) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        db_cnt_q <= '0;
        flip_q   <= 1'b1;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;

  // ---------------- gesture FSM ----------------
  gesto_state_e    state_q;
  logic [CntW-1:0] cnt_q, cnt_inc;
  logic            click_q, dclick_q, hold_q;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;  // saturating

  // Default is to count; any state change overrides with a clear below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      hold_q   <= 1'b0;
      cnt_q    <= cnt_inc;
      if (suppress) begin
        // Combo wins over any per-button transition; pending clicks are dropped.
        if (state_q != StSuppress) begin
          state_q <= StSuppress;
          cnt_q   <= '0;
        end
      end else begin
        case (state_q)
          StIdle: begin
            if (level_q) begin
              state_q <= StPress1;
              cnt_q   <= '0;
            end
          end
          StPress1: begin
            if (!level_q) begin
              state_q <= StWait2;
              cnt_q   <= '0;
            end else if (cnt_q == HoldLast) begin
              hold_q  <= 1'b1;
              state_q <= StHeld;
              cnt_q   <= '0;
            end
          end
          StWait2: begin
            if (level_q) begin
              state_q <= StPress2;
              cnt_q   <= '0;
            end else if (cnt_q == ClickLast) begin
              click_q <= 1'b1;
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end
          StPress2: begin
            if (!level_q) begin
              dclick_q <= 1'b1;
              state_q  <= StIdle;
              cnt_q    <= '0;
            end else if (cnt_q == HoldLast) begin
              hold_q  <= 1'b1;
              state_q <= StHeld;
              cnt_q   <= '0;
            end
          end
          StHeld: begin
            if (!level_q) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end
          end
          StSuppress: begin
            // suppress is low here: both buttons have been released.
            state_q <= StIdle;
            cnt_q   <= '0;
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign click  = click_q;
  assign dclick = dclick_q;
  assign hold   = hold_q;

endmodule

// File: rtl/decodificador_gestos.sv
// Gesture decoder for the two push-buttons. Each button gets a channel
// (synchronizer, debouncer, gesture FSM); this level detects the two-button
// combo and keeps both channels suppressed until both buttons are released.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   b1, b2                - raw buttons, active-high
//   b1_level, b2_level    - debounced levels
//   bN_click/dclick/hold  - one-cycle gesture pulses per button
//   combo                 - one-cycle pulse when both levels become high
module decodificador_gestos
  import decodificador_gestos_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
  parameter int unsigned HOLD_CYC     = DefHoldCyc,
  parameter int unsigned DCLICK_CYC   = DefDclickCyc
) (
  input  logic clk,
  input  logic rst_n,
  input  logic b1,
  input  logic b2,
  output logic b1_level,
  output logic b2_level,
  output logic b1_click,
  output logic b2_click,
  output logic b1_dclick,
  output logic b2_dclick,
  output logic b1_hold,
  output logic b2_hold,
  output logic combo
);

  logic b1_lvl, b2_lvl;
  logic both_q, supp_q, combo_q;
  logic combo_rise, suppress;

  assign combo_rise = b1_lvl & b2_lvl & ~both_q;
  // Entry is immediate on the combo edge; supp_q keeps it until both are low.
  assign suppress   = combo_rise | supp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      both_q  <= 1'b0;
      supp_q  <= 1'b0;
      combo_q <= 1'b0;
    end else begin
      both_q  <= b1_lvl & b2_lvl;
      combo_q <= combo_rise;
      if (combo_rise) begin
        supp_q <= 1'b1;
      end else if (!b1_lvl && !b2_lvl) begin
        supp_q <= 1'b0;
      end
    end
  end

  canal_gesto #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .DCLICK_CYC   (DCLICK_CYC)
  ) u_canal_b1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (b1),
    .suppress (suppress),
    .level    (b1_lvl),
    .click    (b1_click),
    .dclick   (b1_dclick),
    .hold     (b1_hold)
  );

  canal_gesto #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .HOLD_CYC     (HOLD_CYC),
    .DCLICK_CYC   (DCLICK_CYC)
  ) u_canal_b2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw      (b2),
    .suppress (suppress),
    .level    (b2_lvl),
    .click    (b2_click),
    .dclick   (b2_dclick),
    .hold     (b2_hold)
  );

  assign b1_level = b1_lvl;
  assign b2_level = b2_lvl;
  assign combo    = combo_q;

endmodule

// File: tb/tb_decodificador_gestos.sv
// Scoreboard bench: each stimulus pushes the pulses it must produce (which
// output, at which cycle); a negedge monitor pops one entry per observed pulse.
module tb_decodificador_gestos;

  localparam int Deb    = 4;
  localparam int Hold   = 20;
  localparam int Dclk   = 10;
  localparam int LvlLat = Deb + 2;

  localparam int IdB1Click  = 0;
  localparam int IdB1Dclick = 1;
  localparam int IdB1Hold   = 2;
  localparam int IdB2Click  = 3;
  localparam int IdB2Dclick = 4;
  localparam int IdB2Hold   = 5;
  localparam int IdCombo    = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic b1    = 1'b0;
  logic b2    = 1'b0;
  logic b1_level, b2_level, b1_click, b2_click, b1_dclick, b2_dclick;
  logic b1_hold, b2_hold, combo;

  typedef struct {
    int id;
    int cyc;
  } evt_t;

  evt_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  decodificador_gestos #(
    .DEBOUNCE_CYC (Deb),
    .HOLD_CYC     (Hold),
    .DCLICK_CYC   (Dclk)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .b1        (b1),
    .b2        (b2),
    .b1_level  (b1_level),
    .b2_level  (b2_level),
    .b1_click  (b1_click),
    .b2_click  (b2_click),
    .b1_dclick (b1_dclick),
    .b2_dclick (b2_dclick),
    .b1_hold   (b1_hold),
    .b2_hold   (b2_hold),
    .combo     (combo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [8:0] outs();
    return {b1_level, b2_level, b1_click, b2_click, b1_dclick, b2_dclick,
            b1_hold, b2_hold, combo};
  endfunction

  task automatic expect_evt(input int id, input int at);
    evt_t e;
    e.id  = id;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Raw high for len sampling edges, starting at edge cyc+1.
  task automatic press(input int btn, input int len);
    if (btn == 1) b1 = 1'b1; else b2 = 1'b1;
    repeat (len) @(negedge clk);
    if (btn == 1) b1 = 1'b0; else b2 = 1'b0;
  endtask

  // Wait for the scoreboard to empty, then linger to catch late extra pulses.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (25) @(negedge clk);
    check_eq("pending_events", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [6:0] pulses;
    evt_t       e;
    pulses = {combo, b2_hold, b2_dclick, b2_click, b1_hold, b1_dclick, b1_click};
    if (rst_n) begin
      for (int i = 0; i < 7; i++) begin
        if (pulses[i]) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_pulse_id", i, -1);
          end else begin
            e = exp_q.pop_front();
            check_eq("pulse_id", i, e.id);
            check_eq("pulse_cycle", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int s, s2, lat;
    logic mx;

    // Reset
    #1 check_eq("reset_outputs", int'(outs()), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_reset_outputs", int'(outs()), 0);

    // 1. Debounce: short glitch, then level latency both ways
    press(1, 3);
    mx = 1'b0;
    repeat (15) begin
      @(negedge clk);
      mx = mx | b1_level;
    end
    check_eq("glitch_level", int'(mx), 0);

    s = cyc + 1;
    b1 = 1'b1;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (b1_level) lat = cyc - s;
    end
    check_eq("level_rise_latency", lat, LvlLat);
    s = cyc + 1;
    b1 = 1'b0;
    expect_evt(IdB1Click, s + LvlLat + Dclk);
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (!b1_level) lat = cyc - s;
    end
    check_eq("level_fall_latency", lat, LvlLat);
    drain(60);

    // 2. Single click
    s = cyc + 1;
    expect_evt(IdB1Click, s + 8 + LvlLat + Dclk);
    press(1, 8);
    drain(60);

    // 3. Double click on b2
    press(2, 8);
    repeat (5) @(negedge clk);
    s2 = cyc + 1;
    expect_evt(IdB2Dclick, s2 + 8 + LvlLat + 1);
    press(2, 8);
    drain(60);

    // 4. Hold, then silent release
    s = cyc + 1;
    expect_evt(IdB1Hold, s + LvlLat + Hold);
    press(1, 40);
    drain(60);

    // 5. Combo: b1 then b2 two cycles later; no per-button pulses
    b1 = 1'b1;
    repeat (2) @(negedge clk);
    s2 = cyc + 1;
    b2 = 1'b1;
    expect_evt(IdCombo, s2 + LvlLat + 1);
    repeat (30) @(negedge clk);
    check_eq("combo_levels", int'({b1_level, b2_level}), 3);
    b1 = 1'b0;
    b2 = 1'b0;
    drain(60);
    // Suppression released: a plain click works again
    s = cyc + 1;
    expect_evt(IdB1Click, s + 8 + LvlLat + Dclk);
    press(1, 8);
    drain(60);

    // 6. Reset mid-gesture: b1 in WAIT2, b2 debounced high
    s = cyc + 1;
    press(1, 8);
    @(negedge clk);
    b2 = 1'b1;
    while (cyc < s + 8 + LvlLat + 3) @(negedge clk);
    check_eq("pre_reset_b2_level", int'(b2_level), 1);
    #2 rst_n = 1'b0;
    #1 check_eq("mid_reset_outputs", int'(outs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    s = cyc + 1;
    // b2 held through reset is a fresh press
    expect_evt(IdB2Hold, s + LvlLat + Hold);
    repeat (35) @(negedge clk);
    b2 = 1'b0;
    drain(60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
